// File: rtl/register_word_reader.sv
// ---------------------------------------------------------------------------
// register_word_reader
//
// Purpose:
//   Captures one DATA_W-bit word on a load strobe and unloads it as a
//   sequence of CHUNK_W-bit pieces over a VALID/READY stream, so that wide
//   pipeline register stages can feed narrower consumers such as serial
//   links or byte-wide buffers.
//
// Ports:
//   CLK    in   1        clock, all state changes on the rising edge
//   RST    in   1        synchronous active-low reset (0 = reset)
//   EN     in   1        load strobe, Din captured when EN=1 and BUSY=0
//   Din    in   DATA_W   word to unload
//   BUSY   out  1        a word is held and not yet fully transferred
//   Dout   out  CHUNK_W  current piece, 0 when VALID=0
//   VALID  out  1        Dout holds a piece offered to the consumer
//   READY  in   1        consumer accepts, transfer = VALID & READY at edge
//   IDX    out  IDX_W    index of the piece on Dout (0 = first sent)
//   DONE   out  1        one-cycle pulse in the cycle after the last transfer
//
// Configuration:
//   REGISTER_WORD_READER_MSB_FIRST_EN
//     defined   : the most significant piece is sent first
//     undefined : the least significant piece is sent first
//   Handshake, latency and DONE timing are the same in both builds.
// ---------------------------------------------------------------------------
module register_word_reader #(
    parameter int DATA_W  = 32,
    parameter int CHUNK_W = 8,
    localparam int NUM_CH = DATA_W / CHUNK_W,
    localparam int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               EN,
    input  logic [DATA_W-1:0]  Din,
    output logic               BUSY,
    output logic [CHUNK_W-1:0] Dout,
    output logic               VALID,
    input  logic               READY,
    output logic [IDX_W-1:0]   IDX,
    output logic               DONE
);

    // The word must split into a whole number of pieces.
    if (DATA_W % CHUNK_W != 0) begin : g_width_check
        $error("register_word_reader: DATA_W must be a multiple of CHUNK_W");
    end

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH - 1);

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t               state_q, state_d;
    logic [DATA_W-1:0]    shadow_q, shadow_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [CHUNK_W-1:0]   dout_q, dout_d;
    logic                 done_q, done_d;

    // Picks piece k of a word. A shift is used rather than a variable
    // part-select so the selection stays width-clean for any IDX_W.
    function automatic logic [CHUNK_W-1:0] select_piece(
        input logic [DATA_W-1:0] word,
        input logic [IDX_W-1:0]  k
    );
        logic [DATA_W-1:0] shifted;
`ifdef REGISTER_WORD_READER_MSB_FIRST_EN
        shifted = word << (int'(k) * CHUNK_W);
        return shifted[DATA_W-1 -: CHUNK_W];
`else
        shifted = word >> (int'(k) * CHUNK_W);
        return shifted[CHUNK_W-1:0];
`endif
    endfunction

    // Next-state logic. Dout is computed from the next shadow word and
    // index so that the piece is registered alongside the state, keeping
    // READY and EN off any combinational path to the outputs.
    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        idx_d    = idx_q;
        done_d   = 1'b0;
        dout_d   = '0;

        case (state_q)
            IDLE: begin
                // A load in the DONE cycle is legal: DONE is only a pulse,
                // the state is already IDLE.
                if (EN) begin
                    shadow_d = Din;
                    idx_d    = '0;
                    state_d  = SEND;
                end
            end
            SEND: begin
                // EN is ignored here, so the shadow word stays untouched
                // until the last piece has been accepted.
                if (READY) begin
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase

        if (state_d == SEND) begin
            dout_d = select_piece(shadow_d, idx_d);
        end
    end

    // State register with synchronous active-low reset. Reset drops any
    // word in flight without producing DONE.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q  <= IDLE;
            shadow_q <= '0;
            idx_q    <= '0;
            dout_q   <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            idx_q    <= idx_d;
            dout_q   <= dout_d;
            done_q   <= done_d;
        end
    end

    assign VALID = (state_q == SEND);
    assign BUSY  = (state_q == SEND);
    assign Dout  = dout_q;
    assign IDX   = idx_q;
    assign DONE  = done_q;

endmodule

// File: tb/tb_register_word_reader.sv
// ---------------------------------------------------------------------------
// tb_register_word_reader
//
// Directed and random stimulus for register_word_reader. Expected outputs
// come from a reference model that treats a loaded word as a queue of
// pieces: a load pushes all pieces, each accepted transfer pops the head,
// and emptying the queue through a transfer raises DONE for one cycle.
// ---------------------------------------------------------------------------
module tb_register_word_reader;

    localparam int DATA_W  = 32;
    localparam int CHUNK_W = 8;
    localparam int NUM_CH  = DATA_W / CHUNK_W;
    localparam int IDX_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic               CLK;
    logic               RST;
    logic               EN;
    logic [DATA_W-1:0]  Din;
    logic               BUSY;
    logic [CHUNK_W-1:0] Dout;
    logic               VALID;
    logic               READY;
    logic [IDX_W-1:0]   IDX;
    logic               DONE;

    int checks;
    int failures;

    // Reference model state
    logic [CHUNK_W-1:0] pieceQueue[$];
    bit                 modelDone;

    register_word_reader #(
        .DATA_W (DATA_W),
        .CHUNK_W(CHUNK_W)
    ) dut (
        .CLK  (CLK),
        .RST  (RST),
        .EN   (EN),
        .Din  (Din),
        .BUSY (BUSY),
        .Dout (Dout),
        .VALID(VALID),
        .READY(READY),
        .IDX  (IDX),
        .DONE (DONE)
    );

    // Free-running clock, 10 time units per period
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Piece number k of a word in transmission order, written straight
    // from the arithmetic definition of the ordering.
    function automatic logic [CHUNK_W-1:0] piece(input logic [DATA_W-1:0] word, input int k);
`ifdef REGISTER_WORD_READER_MSB_FIRST_EN
        return CHUNK_W'(word >> (DATA_W - (k + 1) * CHUNK_W));
`else
        return CHUNK_W'(word >> (k * CHUNK_W));
`endif
    endfunction

    // Advances the model by one rising edge with the given inputs
    task automatic modelStep(input bit en, input logic [DATA_W-1:0] din,
                             input bit ready, input bit rst);
        if (!rst) begin
            pieceQueue.delete();
            modelDone = 1'b0;
        end else begin
            modelDone = 1'b0;
            if (pieceQueue.size() != 0) begin
                if (ready) begin
                    void'(pieceQueue.pop_front());
                    if (pieceQueue.size() == 0) modelDone = 1'b1;
                end
            end else if (en) begin
                for (int k = 0; k < NUM_CH; k++) pieceQueue.push_back(piece(din, k));
            end
        end
    endtask

    // Compares every output against the model
    task automatic checkOutput(input string tag);
        bit                 expValid;
        logic [CHUNK_W-1:0] expDout;
        logic [IDX_W-1:0]   expIdx;
        expValid = (pieceQueue.size() != 0);
        expDout  = expValid ? pieceQueue[0] : '0;
        expIdx   = expValid ? IDX_W'(NUM_CH - pieceQueue.size()) : '0;

        checks++;
        assert (VALID === expValid) else begin
            failures++;
            $error("[TB] FAIL %s VALID observed=%0b expected=%0b", tag, VALID, expValid);
        end
        checks++;
        assert (BUSY === expValid) else begin
            failures++;
            $error("[TB] FAIL %s BUSY observed=%0b expected=%0b", tag, BUSY, expValid);
        end
        checks++;
        assert (Dout === expDout) else begin
            failures++;
            $error("[TB] FAIL %s Dout observed=%h expected=%h", tag, Dout, expDout);
        end
        checks++;
        assert (IDX === expIdx) else begin
            failures++;
            $error("[TB] FAIL %s IDX observed=%0d expected=%0d", tag, IDX, expIdx);
        end
        checks++;
        assert (DONE === modelDone) else begin
            failures++;
            $error("[TB] FAIL %s DONE observed=%0b expected=%0b", tag, DONE, modelDone);
        end
    endtask

    // Drives one cycle of inputs just after an edge, then checks 1 unit
    // after the following edge
    task automatic applyStimulus(input bit en, input logic [DATA_W-1:0] din,
                                 input bit ready, input bit rst, input string tag);
        EN    = en;
        Din   = din;
        READY = ready;
        RST   = rst;
        @(posedge CLK);
        modelStep(en, din, ready, rst);
        #1;
        checkOutput(tag);
    endtask

    // Literal check of Dout for the fixed-pattern load
    task automatic checkLiteral(input string tag, input logic [CHUNK_W-1:0] expDout);
        checks++;
        assert (Dout === expDout) else begin
            failures++;
            $error("[TB] FAIL %s literal Dout observed=%h expected=%h", tag, Dout, expDout);
        end
    endtask

    initial begin
        logic [CHUNK_W-1:0] litSeq [NUM_CH];
        logic [DATA_W-1:0]  litWord;
        checks    = 0;
        failures  = 0;
        modelDone = 1'b0;
        EN        = 1'b0;
        Din       = '0;
        READY     = 1'b0;
        RST       = 1'b0;

        litWord = 32'hA1B2C3D4;
`ifdef REGISTER_WORD_READER_MSB_FIRST_EN
        litSeq = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
`else
        litSeq = '{8'hD4, 8'hC3, 8'hB2, 8'hA1};
`endif

        $display("[TB] reset");
        applyStimulus(1'b0, '0, 1'b0, 1'b0, "reset0");
        applyStimulus(1'b1, 32'hDEADBEEF, 1'b1, 1'b0, "reset1");
        applyStimulus(1'b0, '0, 1'b0, 1'b1, "idle");

        $display("[TB] full-rate unload");
        applyStimulus(1'b1, litWord, 1'b1, 1'b1, "t1_load");
        checkLiteral("t1_p0", litSeq[0]);
        for (int i = 1; i < NUM_CH; i++) begin
            applyStimulus(1'b0, $urandom, 1'b1, 1'b1, "t1_send");
            checkLiteral("t1_pn", litSeq[i]);
        end
        applyStimulus(1'b0, '0, 1'b1, 1'b1, "t1_done");
        applyStimulus(1'b0, '0, 1'b1, 1'b1, "t1_after");

        $display("[TB] consumer stall");
        applyStimulus(1'b1, litWord, 1'b0, 1'b1, "t2_load");
        applyStimulus(1'b0, $urandom, 1'b0, 1'b1, "t2_stall");
        applyStimulus(1'b0, $urandom, 1'b0, 1'b1, "t2_stall");
        checkLiteral("t2_hold", litSeq[0]);
        for (int i = 0; i < NUM_CH + 1; i++) applyStimulus(1'b0, '0, 1'b1, 1'b1, "t2_send");

        $display("[TB] load while busy");
        applyStimulus(1'b1, 32'h11223344, 1'b1, 1'b1, "t3_load");
        for (int i = 0; i < NUM_CH + 1; i++) applyStimulus(1'b1, 32'hFFFFFFFF, 1'b1, 1'b1, "t3_ignore");
        applyStimulus(1'b0, '0, 1'b1, 1'b1, "t3_after");

        $display("[TB] reset mid-transfer");
        applyStimulus(1'b1, 32'h55667788, 1'b1, 1'b1, "t4_load");
        applyStimulus(1'b0, '0, 1'b1, 1'b1, "t4_send");
        applyStimulus(1'b0, '0, 1'b1, 1'b0, "t4_reset");
        applyStimulus(1'b0, '0, 1'b1, 1'b1, "t4_nodone");
        applyStimulus(1'b1, 32'h01020304, 1'b1, 1'b1, "t4_reload");
        for (int i = 0; i < NUM_CH; i++) applyStimulus(1'b0, '0, 1'b1, 1'b1, "t4_send2");

        $display("[TB] back-to-back load in DONE cycle");
        applyStimulus(1'b1, 32'h0BADF00D, 1'b1, 1'b1, "t5_load");
        for (int i = 0; i < NUM_CH - 1; i++) applyStimulus(1'b0, '0, 1'b1, 1'b1, "t5_send");
        applyStimulus(1'b0, '0, 1'b1, 1'b1, "t5_done");
        applyStimulus(1'b1, 32'hCAFEBABE, 1'b1, 1'b1, "t5_next");
        for (int i = 0; i < NUM_CH; i++) applyStimulus(1'b0, '0, 1'b1, 1'b1, "t5_send2");

        $display("[TB] random traffic");
        for (int i = 0; i < 400; i++) begin
            applyStimulus($urandom_range(0, 1) == 1, $urandom,
                          $urandom_range(0, 9) < 7, $urandom_range(0, 49) != 0, "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
